// File: rtl/upsampler_pkg.sv
// Shared constants, state encoding and helpers for the upsampler
// job arbiter and the vector_upsampler it fronts.
package upsampler_pkg;

    localparam int INPUT_COUNT_DEF   = 128;
    localparam int OUTPUT_COUNT_DEF  = 784;
    localparam int DATA_WIDTH_DEF    = 16;
    localparam int TIMEOUT_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    function automatic int calc_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr_i.
// Ports: req_i (requests), ptr_i (start index), onehot_o/idx_o (winner), any_o.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDW-1:0]     idx_o,
    output logic               any_o
);

    int best_d;
    int d;

    // Winner is the set bit with the smallest wrapped distance from ptr_i.
    always_comb begin
        best_d = NUM_REQ;
        d      = 0;
        idx_o  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j >= int'(ptr_i)) begin
                d = j - int'(ptr_i);
            end else begin
                d = j + NUM_REQ - int'(ptr_i);
            end
            if (req_i[j] && (d < best_d)) begin
                best_d = d;
                idx_o  = IDW'(j);
            end
        end
        any_o    = |req_i;
        onehot_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/upsampler_job_arbiter.sv
// Shares one vector_upsampler between NUM_REQ requesters (round-robin).
// Ports: clk/rst; req/req_vector in; grant/req_done/req_error out;
// us_start/us_vector_in/us_busy/us_done to the upsampler;
// busy/active_id/timeout_count status.
module upsampler_job_arbiter
    import upsampler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int INPUT_COUNT    = INPUT_COUNT_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDW = (NUM_REQ > 1) ? calc_clog2(NUM_REQ) : 1,
    localparam int VW  = DATA_WIDTH * INPUT_COUNT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*VW-1:0]        req_vector,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [NUM_REQ-1:0]           req_error,
    output logic                         us_start,
    output logic [VW-1:0]                us_vector_in,
    input  logic                         us_busy,
    input  logic                         us_done,
    output logic                         busy,
    output logic [IDW-1:0]               active_id,
    output logic [TIMEOUT_CNT_WIDTH-1:0] timeout_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? calc_clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic start_q, start_d;
    logic busy_q, busy_d;
    logic [VW-1:0] vec_q, vec_d;
    logic [IDW-1:0] active_q, active_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TIMEOUT_CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDW-1:0] pick_idx;
    logic pick_any;
    logic [IDW-1:0] rr_next;

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ),
        .IDW    (IDW)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_q),
        .onehot_o(pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign rr_next = (active_q == LAST_ID) ? '0 : active_q + IDW'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        active_d = active_q;
        vec_d    = vec_q;
        rr_d     = rr_q;
        timer_d  = timer_q;
        tcnt_d   = tcnt_q;
        start_d  = 1'b0;
        done_d   = '0;
        err_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_oh;
                    active_d = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IDW'(i)) begin
                            vec_d = req_vector[i*VW +: VW];
                        end
                    end
                    start_d = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // grant_q is the one-hot of active_q, so it doubles as
                // the pulse mask; done beats a coincident timeout.
                if (us_done) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    rr_d    = rr_next;
                    state_d = ST_RELEASE;
                end else if (timer_q == TMAX) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    rr_d    = rr_next;
                    if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + TIMEOUT_CNT_WIDTH'(1);
                    end
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RELEASE: begin
                // An aborted job may still be draining in the upsampler.
                if (!us_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            vec_q    <= '0;
            active_q <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            vec_q    <= vec_d;
            active_q <= active_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign grant         = grant_q;
    assign req_done      = done_q;
    assign req_error     = err_q;
    assign us_start      = start_q;
    assign us_vector_in  = vec_q;
    assign busy          = busy_q;
    assign active_id     = active_q;
    assign timeout_count = tcnt_q;

endmodule

// File: doc/upsampler_job_arbiter.md
Name: upsampler_job_arbiter

Overview:
Shares one vector_upsampler instance between NUM_REQ requesters, for example the generator output path and a debug/test-pattern source.
- Uses round-robin arbitration.
- Latches the winner's input vector and issues a single-cycle start.
- Waits for the upsampler's done.
- Returns a per-requester done or timeout-error pulse.
- Sits between the requesters and the upsampler's start/vector_in/busy/done pins.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
INPUT_COUNT, 128, elements per request vector (matches upsampler)
DATA_WIDTH, 16, bits per element
TIMEOUT_CYCLES, 1024, max WAIT cycles before a job is aborted (must exceed OUTPUT_COUNT+2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  level request per requester; held until req_done/req_error seen
req_vector  in  NUM_REQ*DATA_WIDTH*INPUT_COUNT  flat per-requester vectors; requester i at slice i
grant  out  NUM_REQ  one-hot, high from LAUNCH through WAIT for the served requester
req_done  out  NUM_REQ  one-cycle pulse, job completed
req_error  out  NUM_REQ  one-cycle pulse, job timed out
us_start  out  1  start pulse to upsampler
us_vector_in  out  DATA_WIDTH*INPUT_COUNT  registered vector to upsampler
us_busy  in  1  upsampler busy
us_done  in  1  upsampler done pulse
busy  out  1  high in every state except IDLE
active_id  out  max(1,clog2(NUM_REQ))  index of last/current granted requester
timeout_count  out  8  saturating count of timeouts

Behaviour:
Synchronous reset. Every output and internal register clears on the clk edge with rst=1:
- grant, req_done, req_error, us_start, busy = 0; us_vector_in = 0; active_id = 0; timeout_count = 0.
- State = IDLE; rr_ptr = 0; timer = 0.
- Reset mid-job abandons the job with no done/error pulse. The upsampler shares rst.

States: IDLE, LAUNCH, WAIT, RELEASE. All outputs are registered.
- IDLE
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant (one-hot), active_id, and us_vector_in <= that requester's slice. Go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH (exactly 1 cycle)
  - us_start=1. Clear timer. Go to WAIT.
  - Latency: req sampled at edge N, then us_start high in cycle N+1.
- WAIT
  - us_start=0. timer increments each cycle.
  - If us_done=1: pulse req_done[active_id] in the next cycle, grant<=0, rr_ptr<=active_id+1 (wrap), go to RELEASE.
  - Else if timer==TIMEOUT_CYCLES-1: pulse req_error[active_id], grant<=0, timeout_count<=min(count+1,255), rr_ptr<=active_id+1, go to RELEASE.
  - If us_done and timeout coincide, done wins: no error pulse, no count increment.
- RELEASE (minimum 1 cycle)
  - Stay while us_busy=1 (an aborted job is still draining). Go to IDLE once us_busy=0.
  - req is ignored here, so a requester that drops req on the edge after its pulse is never re-granted.
- Fairness
  - After a job by requester k, priority starts at k+1.
  - With all requests held, requesters are served in strict rotation.
- Ignored inputs
  - us_done outside WAIT is ignored (stale pulse after a timeout).
  - req changes during LAUNCH/WAIT do not affect the current job.
  - The requester's req_vector may change after LAUNCH because the vector is latched.
- Per-job cycle count: 1 (IDLE decision) + 1 (LAUNCH) + upsampler latency + 1 (RELEASE).
- NUM_REQ=1 is legal; arbitration degenerates to a pass-through.

Decomposition:
- Shared package upsampler_pkg:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, RELEASE=3)
  - TIMEOUT_CNT_WIDTH=8
  - calc_clog2 function
  - default INPUT_COUNT/OUTPUT_COUNT/DATA_WIDTH constants shared with vector_upsampler
- One natural sub-module, rr_priority_picker:
  - combinational
  - inputs: req vector, rr_ptr
  - outputs: one-hot winner, index, any_valid

Test Plan:
1. Single requester: req=2'b01, vector elements 0..127 = i. Expect us_start exactly 1 cycle after req sampled and grant=2'b01 in LAUNCH/WAIT. req_done[0] pulses 1 cycle after us_done. Upsampler out element 783 = 127.
2. Round-robin: both req held high for 4 jobs. Grant order is 0,1,0,1. Each req_done precedes the next LAUNCH by exactly 2 cycles (RELEASE+IDLE).
3. Timeout: stub upsampler with us_done never asserted and us_busy high for 1200 cycles. Expect req_error[active_id] in the cycle after timer reaches 1023 and timeout_count=1. RELEASE holds until us_busy falls. A late us_done produces no req_done.
4. Coincidence: force us_done on the same cycle timer reaches TIMEOUT_CYCLES-1. Expect req_done pulse, no req_error, timeout_count unchanged.
5. Reset mid-job: assert rst for 1 cycle while in WAIT. Next cycle: grant=0, busy=0, no pulses, timeout_count=0, and the next req is served starting from requester 0.
6. Vector latch: change req_vector[0] during WAIT. The upsampler output still reflects the vector captured at IDLE→LAUNCH.
